// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared synchronous memory bus.
// Bursts are capped at MAX_BURST while the other master waits; acks return one cycle after issue.
module mem_bus_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a master holds req (with we/addr/wdata stable) and an access
  // is taken in every cycle where req=1 and gnt=1; its ack pulses exactly one
  // cycle later, carrying rdata for reads, regardless of where gnt is by then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_BURST) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          ack_pend_q;
  logic          ack_id_q;

  logic issue0, issue1, issue, last;

  assign issue0 = (state_q == GNT0) && m0_req;
  assign issue1 = (state_q == GNT1) && m1_req;
  assign issue  = issue0 || issue1;
  assign last   = ((cnt_q + CW'(1)) == CW'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = owner_q ? GNT0 : GNT1;
        else if (m0_req)      state_d = GNT0;
        else if (m1_req)      state_d = GNT1;
      end
      GNT0: begin
        if (!m0_req)     state_d = m1_req ? GNT1 : IDLE;
        else if (last) begin
          if (m1_req)    state_d = GNT1;
          else           cnt_d   = '0;
        end
        else             cnt_d   = cnt_q + CW'(1);
      end
      GNT1: begin
        if (!m1_req)     state_d = m0_req ? GNT0 : IDLE;
        else if (last) begin
          if (m0_req)    state_d = GNT0;
          else           cnt_d   = '0;
        end
        else             cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Any transition restarts the burst; entering a grant records the new owner.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == GNT0)      owner_d = 1'b0;
      else if (state_d == GNT1) owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b1;
      ack_pend_q <= 1'b0;
      ack_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ack_pend_q <= issue;
      ack_id_q   <= issue1;
    end
  end

  assign m0_gnt      = (state_q == GNT0);
  assign m1_gnt      = (state_q == GNT1);
  assign owner       = owner_q;
  assign dbg_state_o = state_q;

  assign mem_en    = issue;
  assign mem_we    = issue0 ? m0_we    : (issue1 ? m1_we    : 1'b0);
  assign mem_addr  = issue0 ? m0_addr  : (issue1 ? m1_addr  : '0);
  assign mem_wdata = issue0 ? m0_wdata : (issue1 ? m1_wdata : '0);

  assign m0_ack   = ack_pend_q && !ack_id_q;
  assign m1_ack   = ack_pend_q &&  ack_id_q;
  assign m0_rdata = m0_ack ? mem_rdata : '0;
  assign m1_rdata = m1_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default build plus a MAX_BURST=1 build.
// Memory model returns addr ^ 8'hB5 one cycle after a read strobe.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic       mem_en, mem_we, owner;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [1:0] dbg_state;

  logic       b_m0_req, b_m1_req;
  logic [7:0] b_m0_addr, b_m1_addr;
  logic       b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack;
  logic [7:0] b_m0_rdata, b_m1_rdata;
  logic       b_mem_en, b_mem_we, b_owner;
  logic [7:0] b_mem_addr, b_mem_wdata;
  logic [7:0] b_mem_rdata = 8'h00;
  logic [1:0] b_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .dbg_state_o(dbg_state)
  );

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(1'b0), .m0_addr(b_m0_addr), .m0_wdata(8'h00),
    .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr(b_m1_addr), .m1_wdata(8'h00),
    .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .owner(b_owner), .dbg_state_o(b_dbg_state)
  );

  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? (mem_addr ^ 8'hB5) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m1_req = 0; b_m0_addr = 0; b_m1_addr = 0;
    tick();
    tick();
  endtask

  initial begin
    logic exp_g0;

    // Reset values
    do_reset();
    mid();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_owner", owner, 1);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_state", dbg_state, 0);

    // Single m0 read of 0x10, memory returns 0xA5
    do_reset();
    rst = 0; m0_req = 1; m0_addr = 8'h10;
    mid();
    chk("t1_c0_gnt", m0_gnt, 0);
    tick(); mid();
    chk("t1_c1_gnt", m0_gnt, 1);
    chk("t1_c1_en", mem_en, 1);
    chk("t1_c1_addr", mem_addr, 8'h10);
    chk("t1_c1_we", mem_we, 0);
    chk("t1_c1_m1gnt", m1_gnt, 0);
    chk("t1_c1_ack", m0_ack, 0);
    tick(); m0_req = 0; mid();
    chk("t1_c2_ack", m0_ack, 1);
    chk("t1_c2_rdata", m0_rdata, 8'hA5);
    chk("t1_c2_en", mem_en, 0);
    chk("t1_c2_m1ack", m1_ack, 0);
    chk("t1_c2_m1rdata", m1_rdata, 0);
    tick(); mid();
    chk("t1_c3_ack", m0_ack, 0);
    chk("t1_c3_gnt", m0_gnt, 0);
    chk("t1_c3_owner", owner, 0);
    chk("t1_c3_rdata", m0_rdata, 0);

    // Both request continuously: 4 x m0, 4 x m1, then m0 again
    do_reset();
    rst = 0; m0_req = 1; m1_req = 1; m0_addr = 8'h40; m1_addr = 8'h80;
    for (int k = 1; k <= 12; k++) begin
      tick(); mid();
      exp_g0 = (k <= 4) || (k >= 9);
      chk($sformatf("t2_c%0d_g0", k), m0_gnt, exp_g0);
      chk($sformatf("t2_c%0d_g1", k), m1_gnt, !exp_g0);
      chk($sformatf("t2_c%0d_en", k), mem_en, 1);
      chk($sformatf("t2_c%0d_addr", k), mem_addr, exp_g0 ? 8'h40 : 8'h80);
      chk($sformatf("t2_c%0d_owner", k), owner, !exp_g0);
      chk($sformatf("t2_c%0d_a0", k), m0_ack, ((k >= 2) && (k <= 5)) || (k >= 10));
      chk($sformatf("t2_c%0d_a1", k), m1_ack, (k >= 6) && (k <= 9));
      chk($sformatf("t2_c%0d_r0", k), m0_rdata,
          (((k >= 2) && (k <= 5)) || (k >= 10)) ? 8'hF5 : 8'h00);
      chk($sformatf("t2_c%0d_r1", k), m1_rdata, ((k >= 6) && (k <= 9)) ? 8'h35 : 8'h00);
    end

    // m1 alone writes 6 words: grant kept past MAX_BURST
    do_reset();
    rst = 0; m1_req = 1; m1_we = 1; m1_addr = 8'h20; m1_wdata = 8'h50;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 6) begin
        m1_addr  = 8'(32'h20 + k - 1);
        m1_wdata = 8'(32'h50 + k - 1);
      end else begin
        m1_req = 0;
      end
      mid();
      chk($sformatf("t3_c%0d_g1", k), m1_gnt, 1);
      chk($sformatf("t3_c%0d_en", k), mem_en, k <= 6);
      chk($sformatf("t3_c%0d_we", k), mem_we, k <= 6);
      if (k <= 6) begin
        chk($sformatf("t3_c%0d_addr", k), mem_addr, 32'h20 + k - 1);
        chk($sformatf("t3_c%0d_wdata", k), mem_wdata, 32'h50 + k - 1);
      end
      chk($sformatf("t3_c%0d_a1", k), m1_ack, k >= 2);
      chk($sformatf("t3_c%0d_a0", k), m0_ack, 0);
    end
    tick(); mid();
    chk("t3_end_a1", m1_ack, 0);
    chk("t3_end_g1", m1_gnt, 0);

    // m0 drops req after two accesses while m1 waits
    do_reset();
    rst = 0; m0_req = 1; m1_req = 1; m0_addr = 8'h11; m1_addr = 8'h22;
    tick(); mid();
    chk("t4_c1_g0", m0_gnt, 1);
    chk("t4_c1_addr", mem_addr, 8'h11);
    tick(); mid();
    chk("t4_c2_en", mem_en, 1);
    chk("t4_c2_a0", m0_ack, 1);
    tick(); m0_req = 0; mid();
    chk("t4_c3_en", mem_en, 0);
    chk("t4_c3_g0", m0_gnt, 1);
    chk("t4_c3_g1", m1_gnt, 0);
    chk("t4_c3_a0", m0_ack, 1);
    tick(); mid();
    chk("t4_c4_g1", m1_gnt, 1);
    chk("t4_c4_g0", m0_gnt, 0);
    chk("t4_c4_en", mem_en, 1);
    chk("t4_c4_addr", mem_addr, 8'h22);
    chk("t4_c4_a0", m0_ack, 0);
    chk("t4_c4_owner", owner, 1);
    tick(); m1_req = 0; mid();
    chk("t4_c5_a1", m1_ack, 1);

    // Asynchronous reset in the middle of a burst
    do_reset();
    rst = 0; m0_req = 1; m0_addr = 8'h33;
    tick(); tick(); #1;
    chk("t5_pre_a0", m0_ack, 1);
    chk("t5_pre_g0", m0_gnt, 1);
    #1; rst = 1; #1;
    chk("t5_rst_g0", m0_gnt, 0);
    chk("t5_rst_en", mem_en, 0);
    chk("t5_rst_a0", m0_ack, 0);
    chk("t5_rst_r0", m0_rdata, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_owner", owner, 1);
    tick(); mid();
    chk("t5_hold_a0", m0_ack, 0);
    tick(); rst = 0; m1_req = 1; mid();
    chk("t5_rel_g0", m0_gnt, 0);
    chk("t5_rel_a0", m0_ack, 0);
    tick(); mid();
    chk("t5_arb_g0", m0_gnt, 1);
    chk("t5_arb_owner", owner, 0);
    chk("t5_arb_addr", mem_addr, 8'h33);
    m0_req = 0; m1_req = 0;

    // MAX_BURST=1 build: strict alternation
    do_reset();
    rst = 0; b_m0_req = 1; b_m1_req = 1; b_m0_addr = 8'h01; b_m1_addr = 8'h02;
    for (int k = 1; k <= 6; k++) begin
      tick(); mid();
      chk($sformatf("t6_c%0d_en", k), b_mem_en, 1);
      chk($sformatf("t6_c%0d_addr", k), b_mem_addr, (k % 2 == 1) ? 8'h01 : 8'h02);
    end
    b_m0_req = 0; b_m1_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
